// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences one command at a time through an external combinational ALU
// Optional ADD self-check comparator enabled by defining ALU_SEQ_CHECK_EN.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_sel,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_sel,
    input  logic [8:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [8:0]       rsp_result,
    output logic [3:0]       rsp_sel,
    output logic [CNT_W-1:0] op_count,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       alu_a_q, alu_a_d;
    logic [7:0]       alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [8:0]       rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_sel_q, rsp_sel_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             capture;

    // Next-state and datapath updates; the counter runs down to 0 and the
    // capture happens on the following edge, giving SETTLE_CYCLES+1 cycles
    // from accept to rsp_valid.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_sel_d    = rsp_sel_q;
        op_count_d   = op_count_q;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d   = cmd_a;
                    alu_b_d   = cmd_b;
                    alu_sel_d = cmd_sel;
                    cnt_d     = SETTLE_CYCLES[3:0];
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    capture      = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_sel_d    = alu_sel_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset; reset drops any pending operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            alu_sel_q    <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 9'd0;
            rsp_sel_q    <= 4'd0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_sel_q    <= rsp_sel_d;
            op_count_q   <= op_count_d;
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic chk_err_q, chk_err_d;

    // ADD results are cross-checked at the capture edge; the flag is sticky.
    always_comb begin
        chk_err_d = chk_err_q;
        if (capture && (alu_sel_q == 4'b0000) &&
            (alu_result != ({1'b0, alu_a_q} + {1'b0, alu_b_q}))) begin
            chk_err_d = 1'b1;
        end
    end

    // Sticky error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign chk_err        = 1'b0;
`endif

    assign cmd_ready  = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_sel    = rsp_sel_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  cmd_sel;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [8:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_result;
    logic [3:0]  rsp_sel;
    logic [15:0] op_count;
    logic        chk_err;

    logic        cmd_ready4;
    logic [7:0]  alu_a4;
    logic [7:0]  alu_b4;
    logic [3:0]  alu_sel4;
    logic [8:0]  alu_result4;
    logic        rsp_valid4;
    logic [8:0]  rsp_result4;
    logic [3:0]  rsp_sel4;
    logic [3:0]  op_count4;
    logic        chk_err4;

    int passed = 0;
    int total  = 0;
    int lat;
    logic [3:0] exp4;

`ifdef ALU_SEQ_CHECK_EN
    localparam logic EXP_CHK = 1'b1;
`else
    localparam logic EXP_CHK = 1'b0;
`endif

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_sel(rsp_sel), .op_count(op_count), .chk_err(chk_err)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_result(alu_result4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_result(rsp_result4),
        .rsp_sel(rsp_sel4), .op_count(op_count4), .chk_err(chk_err4)
    );

    // ALU model: ADD 3+4 is deliberately broken to exercise the self-check.
    always_comb begin
        alu_result = {1'b0, alu_a} ^ {1'b0, alu_b};
        case (alu_sel)
            4'd0: alu_result = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: alu_result = {1'b0, alu_a} - {1'b0, alu_b};
            4'd2: alu_result = {1'b0, alu_a & alu_b};
            default: ;
        endcase
        if (alu_sel == 4'd0 && alu_a == 8'd3 && alu_b == 8'd4) alu_result = 9'h000;
    end

    assign alu_result4 = {1'b0, alu_a4} + {1'b0, alu_b4};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic [8:0] exp_res);
        int n;
        cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1; rsp_ready = 1'b1;
        step();
        chk("op_accept", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        wait_rsp(n);
        chk("op_latency", n, 32'd2);
        chk("op_result", {23'd0, rsp_result}, {23'd0, exp_res});
        chk("op_sel", {28'd0, rsp_sel}, {28'd0, sel});
        step();
        chk("op_done", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_sel = 4'd0;
        rsp_ready = 1'b0;
        step(); step();
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_rsp_result", {23'd0, rsp_result}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        chk("rst_chk_err", {31'd0, chk_err}, 32'd0);
        rst = 1'b0;
        step();

        // ADD 255+0 with exact latency tracking
        cmd_a = 8'd255; cmd_b = 8'd0; cmd_sel = 4'd0; cmd_valid = 1'b1; rsp_ready = 1'b1;
        step();
        chk("a1_alu_a", {24'd0, alu_a}, 32'd255);
        chk("a1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        step();
        chk("a1_rsp_early", {31'd0, rsp_valid}, 32'd0);
        step();
        chk("a1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("a1_result", {23'd0, rsp_result}, 32'd255);
        chk("a1_sel", {28'd0, rsp_sel}, 32'd0);
        step();
        chk("a1_rsp_clear", {31'd0, rsp_valid}, 32'd0);
        chk("a1_op_count", {16'd0, op_count}, 32'd1);
        chk("a1_cmd_ready_back", {31'd0, cmd_ready}, 32'd1);

        // Back-to-back ADD 240+15 then ADD 255+255
        cmd_a = 8'd240; cmd_b = 8'd15; cmd_valid = 1'b1;
        step();
        cmd_a = 8'd255; cmd_b = 8'd255;
        wait_rsp(lat);
        chk("b2b1_latency", lat, 32'd2);
        chk("b2b1_result", {23'd0, rsp_result}, 32'd255);
        step();
        chk("b2b1_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("b2b1_op_count", {16'd0, op_count}, 32'd2);
        step();
        chk("b2b2_alu_a", {24'd0, alu_a}, 32'd255);
        chk("b2b2_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("b2b2_latency", lat, 32'd2);
        chk("b2b2_result", {23'd0, rsp_result}, 32'h1FE);
        step();
        chk("b2b2_op_count", {16'd0, op_count}, 32'd3);

        // Backpressure: SUB 10-3 held for 5 cycles while a new command waits
        rsp_ready = 1'b0;
        cmd_a = 8'd10; cmd_b = 8'd3; cmd_sel = 4'd1; cmd_valid = 1'b1;
        step();
        cmd_a = 8'd1; cmd_b = 8'd1; cmd_sel = 4'd0;
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_result", {23'd0, rsp_result}, 32'd7);
            chk("bp_sel", {28'd0, rsp_sel}, 32'd1);
            chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("bp_alu_a_hold", {24'd0, alu_a}, 32'd10);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_handshake", {31'd0, rsp_valid}, 32'd0);
        chk("bp_op_count", {16'd0, op_count}, 32'd4);
        chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        step();
        chk("bp_next_accept", {24'd0, alu_a}, 32'd1);
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("bp_next_result", {23'd0, rsp_result}, 32'd2);
        step();
        chk("bp_next_op_count", {16'd0, op_count}, 32'd5);

        // Reset one cycle after accept
        cmd_a = 8'd5; cmd_b = 8'd5; cmd_sel = 4'd0; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_op_count", {16'd0, op_count}, 32'd0);
        chk("mr_alu_a", {24'd0, alu_a}, 32'd0);
        chk("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("mr_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        end
        chk("mr_op_count_after", {16'd0, op_count}, 32'd0);

        // Self-check: broken ADD 3+4, then a correct ADD
        do_op(8'd3, 8'd4, 4'd0, 9'h000);
        chk("chk_err_set", {31'd0, chk_err}, {31'd0, EXP_CHK});
        do_op(8'd1, 8'd2, 4'd0, 9'd3);
        chk("chk_err_sticky", {31'd0, chk_err}, {31'd0, EXP_CHK});
        do_op(8'hF0, 8'h3C, 4'd2, 9'h030);
        chk("chk_err_non_add", {31'd0, chk_err}, {31'd0, EXP_CHK});

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 13; i++) begin
            do_op(i[7:0], 8'd100, 4'd0, 9'(i + 100));
            exp4 = 4'(4 + i);
            chk("wrap_op_count", {16'd0, op_count}, 32'(4 + i));
            chk("wrap_op_count4", {28'd0, op_count4}, {28'd0, exp4});
        end
        chk("wrap_final_main", {16'd0, op_count}, 32'd16);
        chk("wrap_final_cnt4", {28'd0, op_count4}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
